clip_sequencer: RTL and testbench
=================================

# clip_sequencer

Playback controller for the on-board wav sample memory. It accepts up to four debounced play requests, chooses one by fixed priority and queues the rest. It sequences byte reads from the shared sample memory at the audio sample rate and presents each byte with a valid strobe to the downstream 1-bit PWM audio stage. It sits between the pushbutton debouncers, the sample ROM and the PWM output, and also drives the status LEDs and 7-segment display.

## Interface
- `ADDR_W`, 20, sample memory address width.
- `SAMPLE_DIV`, 1536, clock cycles per sample (10 MHz / 1536 ≈ 6.5 kHz). Must be ≥ 4.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 4: one-cycle play-request pulses, one per clip; index 0 has highest priority.
- `stop` in 1: one-cycle abort pulse.
- `clip_start` in 4*ADDR_W: packed start addresses; clip i is at bits [i*ADDR_W +: ADDR_W].
- `clip_len` in 4*ADDR_W: packed clip lengths in bytes, same packing.
- `mem_rdata` in 8: memory read data, valid the cycle after `mem_rd`.
- `mem_rd` out 1: memory read strobe, registered.
- `mem_addr` out ADDR_W: memory read address, registered.
- `sample` out 8: current sample byte, registered; 8'h80 means silence.
- `sample_vld` out 1: one-cycle pulse when `sample` updates with clip data.
- `busy` out 1: a clip is playing.
- `clip_id` out 2: index of the clip playing or last played.
- `pending` out 4: queued requests.
- `done` out 1: one-cycle pulse when a clip finishes normally.

## Operation
- **States:** IDLE and PLAY. PLAY uses a sample-period counter `cnt` (0..SAMPLE_DIV-1) and a byte index `idx` (0..len-1).
- **IDLE:** if (`req` | `pending`) is non-zero and `stop` = 0, grant the lowest set index i. Then:
  - clear `pending[i]`;
  - load `clip_id` = i, `idx` = 0, `cnt` = 0;
  - enter PLAY.
- **PLAY, `cnt` == 0 and `idx` < len:** assert `mem_rd` with `mem_addr` = start + idx. The sum wraps modulo 2^ADDR_W.
- **PLAY, `cnt` == 1:** capture `mem_rdata`.
- **PLAY, `cnt` == 2:** drive the captured byte onto `sample` and pulse `sample_vld`.
- **PLAY, `cnt` == SAMPLE_DIV-1:** wrap `cnt` to 0 and increment `idx`.
- **End of clip:** when `idx` reaches len and `cnt` == 2, return to IDLE. In that same transition `done` = 1, `busy` = 0 and `sample` = 8'h80.
- **Zero-length clip:** len = 0 enters PLAY and ends at `cnt` == 2 with `done`. No `mem_rd` is issued and no `sample_vld` pulse occurs.
- **`req[i]` while busy:**
  - sets `pending[i]` if i ≠ `clip_id`;
  - is ignored if i == `clip_id`;
  - a request for an already-pending clip has no further effect.
  - There is no preemption.
- **`stop`:** in any state, the next cycle shows:
  - `busy` = 0, `mem_rd` = 0, `sample` = 8'h80, `pending` = 0;
  - no `done` pulse.
  - `stop` wins over a simultaneous `req`, and that `req` is dropped.
- **Sampling of `clip_start`/`clip_len`:** both are sampled at grant only. Later changes do not affect the playing clip.
- **Reset values:**
  - `mem_rd` = 0, `mem_addr` = 0, `sample` = 8'h80, `sample_vld` = 0;
  - `busy` = 0, `clip_id` = 0, `pending` = 0, `done` = 0;
  - FSM state IDLE.
- **Reset mid-playback:** returns all of the above immediately (asynchronous). Queued requests are lost.

## Timing
All outputs are registered. The cycle numbers below are relative to a `req` pulse in cycle 0 while idle.
- Cycle 1: `busy` = 1, `clip_id` = i, `mem_rd` = 1, `mem_addr` = start.
- Cycle 2: `mem_rdata` is valid and captured.
- Cycle 3: `sample` = byte 0, `sample_vld` = 1.
- Byte k: `mem_rd` in cycle 1 + k·SAMPLE_DIV; `sample_vld` in cycle 3 + k·SAMPLE_DIV. Each byte is held exactly SAMPLE_DIV cycles.
- Cycle 3 + len·SAMPLE_DIV: `done` = 1, `busy` = 0, `sample` = 8'h80.
- **Back-to-back:** if `pending` is non-zero at `done`, the next clip has `busy` = 1 and `mem_rd` = 1 one cycle after `done`. `busy` is low for exactly one cycle between clips.
- `sample_vld` and `done` are never high in the same cycle.

## Test plan
1. **Single clip.** SAMPLE_DIV = 8; clip 1 has start = 16, len = 3; memory holds 0x10, 0x20, 0x30; `req[1]` pulses at cycle 0.
   - `mem_rd` at cycles 1, 9, 17 with addresses 16, 17, 18.
   - `sample_vld` at cycles 3, 11, 19 with `sample` = 0x10, 0x20, 0x30.
   - `done` at cycle 27; `sample` = 0x80.
2. **Priority.** `req` = 4'b1010 in the same cycle while idle → `clip_id` = 1, `pending` = 4'b1000. After `done`, clip 3 starts one cycle later, following exactly one cycle with `busy` = 0.
3. **Queue and duplicate.** During clip 2: `req[2]` → `pending` unchanged; `req[0]` → `pending[0]` set. Clip 2 is not preempted, and clip 0 plays after it.
4. **Stop.** `stop` pulsed mid-clip with `pending` = 4'b0001 → next cycle `busy` = 0, `sample` = 0x80, `pending` = 0, no `done`. The same cycle of `stop` together with `req[2]` while idle → nothing starts.
5. **Edge lengths and wrap.** len = 0 → `done` at cycle 3, no `mem_rd`, no `sample_vld`. start = 2^ADDR_W − 1 with len = 2 → addresses 0xFFFFF then 0x00000.
6. **Reset mid-play.** `rst` asserted mid-clip → all outputs at reset values immediately. After release, `req[0]` gives `mem_rd` one cycle later.

Source files
------------

// File: rtl/clip_sequencer_if.sv
// rtl/clip_sequencer_if.sv - request, sample-memory and playback status bundle for clip_sequencer
interface clip_sequencer_if #(
  parameter int ADDR_W = 20
);
  logic [3:0]          req;
  logic                stop;
  logic [4*ADDR_W-1:0] clip_start;
  logic [4*ADDR_W-1:0] clip_len;
  logic [7:0]          mem_rdata;
  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          sample;
  logic                sample_vld;
  logic                busy;
  logic [1:0]          clip_id;
  logic [3:0]          pending;
  logic                done;

  modport master (
    input  req, stop, clip_start, clip_len, mem_rdata,
    output mem_rd, mem_addr, sample, sample_vld, busy, clip_id, pending, done
  );

  modport slave (
    output req, stop, clip_start, clip_len, mem_rdata,
    input  mem_rd, mem_addr, sample, sample_vld, busy, clip_id, pending, done
  );
endinterface

// File: rtl/clip_sequencer.sv
// rtl/clip_sequencer.sv - priority-queued clip playback sequencer for the wav sample memory
module clip_sequencer #(
  parameter int ADDR_W     = 20,
  parameter int SAMPLE_DIV = 1536
) (
  input  logic            clk,
  input  logic            rst,
  clip_sequencer_if.master bus
);
  typedef enum logic {IDLE, PLAY} state_t;

  localparam int                 CNT_W    = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   start_r;
  logic [ADDR_W-1:0]   len_r;

  logic                mem_rd_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          sample_q;
  logic                sample_vld_q;
  logic                busy_q;
  logic [1:0]          clip_id_q;
  logic [3:0]          pending_q;
  logic                done_q;

  logic [3:0]          cand;
  logic [1:0]          grant_id;
  logic                grant_any;
  logic [ADDR_W-1:0]   grant_start;
  logic [ADDR_W-1:0]   grant_len;
  logic [ADDR_W-1:0]   idx_nxt;
  logic [3:0]          req_queue;

  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.sample     = sample_q;
  assign bus.sample_vld = sample_vld_q;
  assign bus.busy       = busy_q;
  assign bus.clip_id    = clip_id_q;
  assign bus.pending    = pending_q;
  assign bus.done       = done_q;

  // Fixed-priority pick among fresh and queued requests; index 0 wins.
  always_comb begin
    cand     = bus.req | pending_q;
    grant_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) grant_id = 2'(i);
    end
    grant_any   = |cand;
    grant_start = bus.clip_start[grant_id*ADDR_W +: ADDR_W];
    grant_len   = bus.clip_len[grant_id*ADDR_W +: ADDR_W];
    idx_nxt     = idx + 1'b1;
    // A request for the clip already playing is dropped rather than queued.
    req_queue   = bus.req & ~(4'b0001 << clip_id_q);
  end

  // Playback FSM; every output is registered so it reflects the cnt/idx of the cycle it appears in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      start_r      <= '0;
      len_r        <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      sample_q     <= 8'h80;
      sample_vld_q <= 1'b0;
      busy_q       <= 1'b0;
      clip_id_q    <= 2'd0;
      pending_q    <= 4'd0;
      done_q       <= 1'b0;
    end else begin
      mem_rd_q     <= 1'b0;
      sample_vld_q <= 1'b0;
      done_q       <= 1'b0;
      if (bus.stop) begin
        state     <= IDLE;
        busy_q    <= 1'b0;
        sample_q  <= 8'h80;
        pending_q <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (grant_any) begin
              pending_q  <= cand & ~(4'b0001 << grant_id);
              clip_id_q  <= grant_id;
              idx        <= '0;
              cnt        <= '0;
              start_r    <= grant_start;
              len_r      <= grant_len;
              busy_q     <= 1'b1;
              state      <= PLAY;
              // First read goes out with the grant so it lands in the cnt==0 cycle.
              mem_rd_q   <= (grant_len != '0);
              mem_addr_q <= grant_start;
            end
          end
          PLAY: begin
            pending_q <= pending_q | req_queue;
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              idx        <= idx_nxt;
              mem_rd_q   <= (idx_nxt < len_r);
              mem_addr_q <= start_r + idx_nxt;
            end else begin
              cnt <= cnt + 1'b1;
            end
            // Read data is valid in the cnt==1 cycle; it shows on sample in the cnt==2 cycle.
            if (cnt == CNT_W'(1)) begin
              if (idx < len_r) begin
                sample_q     <= bus.mem_rdata;
                sample_vld_q <= 1'b1;
              end else begin
                state    <= IDLE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                sample_q <= 8'h80;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clip_sequencer.sv
// tb/tb_clip_sequencer.sv - scoreboard bench for clip_sequencer
module tb_clip_sequencer;
  localparam int AW  = 20;
  localparam int DIV = 8;

  typedef struct {
    int c;
    int v;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  rd_q[$];
  ev_t  vld_q[$];
  int   done_q[$];

  clip_sequencer_if #(.ADDR_W(AW)) bus ();

  clip_sequencer #(.ADDR_W(AW), .SAMPLE_DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mem_byte(int a);
    if (a >= 16 && a <= 18) return (a - 15) * 16;
    return (a & 255) ^ 8'hA5;
  endfunction

  // Sample memory: one-cycle read latency.
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= 8'(mem_byte(int'(bus.mem_addr)));

  task automatic check(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_clip(int c0, int start, int len);
    for (int k = 0; k < len; k++) begin
      int a;
      a = (start + k) & ((1 << AW) - 1);
      rd_q.push_back('{c0 + 1 + k * DIV, a});
      vld_q.push_back('{c0 + 3 + k * DIV, mem_byte(a)});
    end
    done_q.push_back(c0 + 3 + len * DIV);
  endtask

  // Output monitor: pop and compare every strobe the DUT produces.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd) begin
        if (rd_q.size() == 0) check("unexpected_mem_rd", cyc, -1);
        else begin
          ev_t e;
          e = rd_q.pop_front();
          check("mem_rd_cycle", cyc, e.c);
          check("mem_addr", int'(bus.mem_addr), e.v);
        end
      end
      if (bus.sample_vld) begin
        if (vld_q.size() == 0) check("unexpected_sample_vld", cyc, -1);
        else begin
          ev_t e;
          e = vld_q.pop_front();
          check("sample_vld_cycle", cyc, e.c);
          check("sample", int'(bus.sample), e.v);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) check("unexpected_done", cyc, -1);
        else check("done_cycle", cyc, done_q.pop_front());
        check("done_sample_silent", int'(bus.sample), 8'h80);
      end
      if (bus.sample_vld || bus.done) check("vld_done_exclusive", int'(bus.sample_vld && bus.done), 0);
    end
  end

  task automatic step_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_req(logic [3:0] r);
    bus.req = r;
    @(negedge clk);
    bus.req = 4'd0;
  endtask

  task automatic set_clip(int i, int start, int len);
    bus.clip_start[i*AW +: AW] = AW'(start);
    bus.clip_len[i*AW +: AW]   = AW'(len);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_mem_rd"}, int'(bus.mem_rd), 0);
    check({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
    check({tag, "_sample"}, int'(bus.sample), 8'h80);
    check({tag, "_sample_vld"}, int'(bus.sample_vld), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_clip_id"}, int'(bus.clip_id), 0);
    check({tag, "_pending"}, int'(bus.pending), 0);
    check({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    int c0;
    int c1;
    cyc = 0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = 4'd0;
    bus.stop = 1'b0;
    bus.clip_start = '0;
    bus.clip_len = '0;
    set_clip(0, 300, 1);
    set_clip(1, 16, 3);
    set_clip(2, 200, 2);
    set_clip(3, 100, 1);
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single clip; clip_len change mid-play must not matter.
    c0 = cyc;
    exp_clip(c0, 16, 3);
    pulse_req(4'b0010);
    check("t1_busy", int'(bus.busy), 1);
    check("t1_clip_id", int'(bus.clip_id), 1);
    step_to(c0 + 5);
    set_clip(1, 16, 7);
    step_to(c0 + 27);
    check("t1_busy_after_done", int'(bus.busy), 0);
    set_clip(1, 16, 3);
    step_to(c0 + 32);

    // Priority and back-to-back.
    c0 = cyc;
    exp_clip(c0, 16, 3);
    exp_clip(c0 + 27, 100, 1);
    pulse_req(4'b1010);
    check("t2_clip_id", int'(bus.clip_id), 1);
    check("t2_pending", int'(bus.pending), 4'b1000);
    step_to(c0 + 26);
    check("t2_busy_before_done", int'(bus.busy), 1);
    step_to(c0 + 27);
    check("t2_busy_gap", int'(bus.busy), 0);
    step_to(c0 + 28);
    check("t2_busy_next", int'(bus.busy), 1);
    check("t2_clip_id_next", int'(bus.clip_id), 3);
    check("t2_pending_next", int'(bus.pending), 0);
    step_to(c0 + 42);

    // Queue and duplicate request.
    c0 = cyc;
    exp_clip(c0, 200, 2);
    exp_clip(c0 + 19, 300, 1);
    pulse_req(4'b0100);
    step_to(c0 + 4);
    pulse_req(4'b0100);
    check("t3_dup_pending", int'(bus.pending), 0);
    step_to(c0 + 6);
    pulse_req(4'b0001);
    check("t3_queue_pending", int'(bus.pending), 4'b0001);
    check("t3_no_preempt", int'(bus.clip_id), 2);
    step_to(c0 + 20);
    check("t3_clip0_id", int'(bus.clip_id), 0);
    check("t3_clip0_busy", int'(bus.busy), 1);
    step_to(c0 + 35);

    // Stop mid-clip, then stop with simultaneous req while idle.
    c0 = cyc;
    rd_q.push_back('{c0 + 1, 16});
    vld_q.push_back('{c0 + 3, 8'h10});
    pulse_req(4'b0010);
    step_to(c0 + 2);
    pulse_req(4'b0001);
    check("t4_pending", int'(bus.pending), 4'b0001);
    step_to(c0 + 5);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("t4_busy", int'(bus.busy), 0);
    check("t4_sample", int'(bus.sample), 8'h80);
    check("t4_pending_clr", int'(bus.pending), 0);
    check("t4_mem_rd", int'(bus.mem_rd), 0);
    step_to(c0 + 40);
    c1 = cyc;
    bus.stop = 1'b1;
    bus.req = 4'b0100;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.req = 4'd0;
    step_to(c1 + 2);
    check("t4_stop_wins_busy", int'(bus.busy), 0);
    check("t4_stop_wins_pending", int'(bus.pending), 0);
    step_to(c1 + 30);

    // Zero length and address wrap.
    set_clip(0, 300, 0);
    c0 = cyc;
    done_q.push_back(c0 + 3);
    pulse_req(4'b0001);
    step_to(c0 + 6);
    set_clip(3, (1 << AW) - 1, 2);
    c1 = cyc;
    exp_clip(c1, (1 << AW) - 1, 2);
    pulse_req(4'b1000);
    step_to(c1 + 25);
    set_clip(0, 300, 1);

    // Reset mid-play.
    c0 = cyc;
    rd_q.push_back('{c0 + 1, 16});
    vld_q.push_back('{c0 + 3, 8'h10});
    pulse_req(4'b0010);
    step_to(c0 + 2);
    pulse_req(4'b0001);
    step_to(c0 + 5);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    step_to(c0 + 8);
    c1 = cyc;
    exp_clip(c1, 300, 1);
    pulse_req(4'b0001);
    check("t6_mem_rd_after_reset", int'(bus.mem_rd), 1);
    step_to(c1 + 15);

    check("rd_queue_empty", rd_q.size(), 0);
    check("vld_queue_empty", vld_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
